arb8_scheduler: RTL and testbench
=================================

ARB8_SCHEDULER -- requirements
Module: arb8_scheduler

Interface
REQ-001 SHALL have parameter: HOLD_MAX, 15, maximum grant tenure in cycles (0 = unlimited).
REQ-002 SHALL have parameter: CNT_W, 4, tenure counter width; HOLD_MAX SHALL fit in CNT_W bits.
REQ-003 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port: req  input  8  request lines; bit i = requester i.
REQ-006 SHALL have port: release  input  1  current owner done; sampled only while granted.
REQ-007 SHALL have port: gnt  output  8  one-hot grant, registered.
REQ-008 SHALL have port: gnt_code  output  3  binary index of owner, registered.
REQ-009 SHALL have port: gnt_valid  output  1  high while any grant is held, registered.
REQ-010 SHALL have port: z  output  1  combinational; 1 when req == 8'b0.
REQ-011 SHALL have port: timeout  output  1  one-cycle pulse on forced revoke, registered.

Function
REQ-012 SHALL implement two states: IDLE (no owner), OWN (one owner).
REQ-013 SHALL hold a 3-bit round-robin pointer ptr; winner = first set req bit searching ptr, ptr+1, ... 7, 0, ... ptr-1.
REQ-014 IDLE with req != 0 at an edge SHALL enter OWN; gnt/gnt_code/gnt_valid valid in the following cycle (1-cycle latency).
REQ-015 IDLE with req == 0 SHALL remain IDLE; gnt=0, gnt_valid=0, gnt_code holds last value.
REQ-016 In OWN, tenure counter SHALL read 1 in first grant cycle and increment each cycle held; saturate, never wrap.
REQ-017 OWN exit conditions, evaluated each edge: release==1, or req[gnt_code]==0, or (HOLD_MAX!=0 and tenure==HOLD_MAX).
REQ-018 On exit, ptr SHALL become gnt_code+1 (mod 8, 7 wraps to 0).
REQ-019 On exit with any req bit set, SHALL grant next winner (searched from new ptr, current req) in the next cycle with no idle bubble; otherwise enter IDLE.
REQ-020 Former owner SHALL re-win only if it is the sole requester; tenure restarts at 1.
REQ-021 timeout SHALL pulse high for exactly one cycle, the cycle after a revoke caused solely by tenure==HOLD_MAX.
REQ-022 release==1 or req[owner]==0 in the same cycle as tenure==HOLD_MAX SHALL count as normal exit; timeout stays 0.
REQ-023 req changes on non-owner bits during OWN SHALL not affect the current grant.
REQ-024 gnt SHALL always be one-hot or zero and equal (1 << gnt_code) whenever gnt_valid==1.
REQ-025 HOLD_MAX==0 SHALL disable forced revoke; timeout never asserts.

Reset
REQ-026 reset==1 at an edge SHALL force: state IDLE, ptr=0, tenure=0, gnt=0, gnt_code=0, gnt_valid=0, timeout=0.
REQ-027 reset SHALL override all other inputs, including mid-tenure; grant drops in the cycle after the reset edge, no timeout pulse.
REQ-028 First arbitration after reset release SHALL search from bit 0.

Verification
REQ-029 Reset, then req=8'b0000_1000 -> next cycle gnt=8'b0000_1000, gnt_code=3, gnt_valid=1, z=0; req=0 -> z=1 same cycle.
REQ-030 req=8'hFF held, release pulsed in 2nd cycle of each grant -> gnt_code sequence 0,1,2,...,7,0 with no bubble cycles.
REQ-031 Owner 4 with req=8'b0001_1000, release -> next cycle gnt_code=3 (wrap search from 5), gnt_valid stays 1.
REQ-032 HOLD_MAX=4, req=8'b0010_0001, release never asserted -> owner 0 held 4 cycles, then gnt_code=5 and timeout=1 for one cycle.
REQ-033 Same as REQ-032 but release=1 in 4th cycle -> gnt_code=5 next, timeout remains 0.
REQ-034 reset asserted during OWN (owner 6) -> next cycle gnt=0, gnt_code=0, gnt_valid=0, timeout=0; subsequent req=8'hC0 grants 6.

Source files
------------

// File: rtl/arb8_scheduler.sv
// 8-way round-robin arbiter with grant tenure limit and forced-revoke pulse.
// The release input is named release_i because "release" is a reserved word.
module arb8_scheduler #(
  parameter int unsigned HOLD_MAX = 15,
  parameter int unsigned CNT_W    = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] req,
  input  logic       release_i,
  output logic [7:0] gnt,
  output logic [2:0] gnt_code,
  output logic       gnt_valid,
  output logic       z,
  output logic       timeout
);

  typedef enum logic {IDLE, OWN} state_e;

  state_e           state_q;
  logic [2:0]       ptr_q;
  logic [CNT_W-1:0] tenure_q;

  logic       hold_hit_c;
  logic       exit_c;
  logic       force_c;
  logic [2:0] base_c;
  logic [2:0] win_c;

  assign z = (req == 8'b0);

  // Exit decision and round-robin search; after an exit the search starts past the owner.
  always_comb begin
    hold_hit_c = (HOLD_MAX != 0) && (tenure_q == CNT_W'(HOLD_MAX));
    exit_c     = release_i || !req[gnt_code] || hold_hit_c;
    force_c    = hold_hit_c && !release_i && req[gnt_code];
    base_c     = (state_q == OWN) ? gnt_code + 3'd1 : ptr_q;
    win_c      = base_c;
    for (int i = 7; i >= 0; i--) begin
      if (req[base_c + 3'(i)]) win_c = base_c + 3'(i);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      ptr_q     <= 3'd0;
      tenure_q  <= '0;
      gnt       <= 8'b0;
      gnt_code  <= 3'd0;
      gnt_valid <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      timeout <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req != 8'b0) begin
            state_q   <= OWN;
            gnt       <= 8'b1 << win_c;
            gnt_code  <= win_c;
            gnt_valid <= 1'b1;
            tenure_q  <= CNT_W'(1);
          end
        end
        OWN: begin
          if (exit_c) begin
            ptr_q   <= gnt_code + 3'd1;
            timeout <= force_c;
            if (req != 8'b0) begin
              gnt      <= 8'b1 << win_c;
              gnt_code <= win_c;
              tenure_q <= CNT_W'(1);
            end else begin
              state_q   <= IDLE;
              gnt       <= 8'b0;
              gnt_valid <= 1'b0;
              tenure_q  <= '0;
            end
          end else if (tenure_q != {CNT_W{1'b1}}) begin
            tenure_q <= tenure_q + CNT_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_arb8_scheduler.sv
// Bench for arb8_scheduler: per-cycle vector table through an expected-value queue,
// plus a hand-written sequence on a second instance with tenure limit disabled.
module tb_arb8_scheduler;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] req = 8'b0;
  logic       rel = 1'b0;
  logic [7:0] gnt, gnt0;
  logic [2:0] gnt_code, gnt_code0;
  logic       gnt_valid, gnt_valid0, z, z0, timeout, timeout0;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  arb8_scheduler #(.HOLD_MAX(4), .CNT_W(4)) u_dut (
    .clk(clk), .reset(reset), .req(req), .release_i(rel),
    .gnt(gnt), .gnt_code(gnt_code), .gnt_valid(gnt_valid), .z(z), .timeout(timeout)
  );

  arb8_scheduler #(.HOLD_MAX(0), .CNT_W(4)) u_dut0 (
    .clk(clk), .reset(reset), .req(req), .release_i(rel),
    .gnt(gnt0), .gnt_code(gnt_code0), .gnt_valid(gnt_valid0), .z(z0), .timeout(timeout0)
  );

  typedef struct {
    logic       rst;
    logic [7:0] req;
    logic       rel;
    logic       v;
    logic [2:0] c;
    logic       to;
  } vec_t;

  typedef struct {
    logic [7:0] gnt;
    logic [2:0] c;
    logic       v;
    logic       to;
  } exp_t;

  vec_t vecs[$];
  exp_t exp_q[$];

  function automatic void add(logic r, logic [7:0] rq, logic rl, logic v, logic [2:0] c, logic to);
    vec_t e;
    e.rst = r; e.req = rq; e.rel = rl; e.v = v; e.c = c; e.to = to;
    vecs.push_back(e);
  endfunction

  task automatic check(string name, int idx, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s[%0d]: got %0h, expected %0h", name, idx, act, exp);
  endtask

  // Drive one cycle of stimulus, queue its expectation, compare after the edge.
  task automatic apply(int idx, vec_t e);
    exp_t x, got;
    @(negedge clk);
    reset = e.rst; req = e.req; rel = e.rel;
    #1;
    check("z", idx, 32'(z), 32'(e.req == 8'b0));
    x.v = e.v; x.c = e.c; x.to = e.to;
    x.gnt = e.v ? (8'b1 << e.c) : 8'b0;
    exp_q.push_back(x);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      checks++;
      $display("FAIL scoreboard[%0d]: got empty queue, expected one entry", idx);
    end else begin
      got = exp_q.pop_front();
      check("gnt", idx, 32'(gnt), 32'(got.gnt));
      check("gnt_code", idx, 32'(gnt_code), 32'(got.c));
      check("gnt_valid", idx, 32'(gnt_valid), 32'(got.v));
      check("timeout", idx, 32'(timeout), 32'(got.to));
    end
  endtask

  initial begin
    // reset, single requester, z, wrap search from 5
    add(1, 8'h00, 0, 0, 0, 0);
    add(0, 8'h08, 0, 1, 3, 0);
    add(0, 8'h00, 0, 0, 3, 0);
    add(0, 8'h10, 0, 1, 4, 0);
    add(0, 8'h18, 1, 1, 3, 0);
    add(0, 8'h00, 0, 0, 3, 0);
    // reset mid-tenure of owner 6, then first search from bit 0
    add(0, 8'h40, 0, 1, 6, 0);
    add(0, 8'h40, 0, 1, 6, 0);
    add(1, 8'h40, 0, 0, 0, 0);
    add(0, 8'hC0, 0, 1, 6, 0);
    add(0, 8'h00, 0, 0, 6, 0);
    // all requesting, release in second grant cycle: 0..7,0 without bubbles
    add(1, 8'h00, 0, 0, 0, 0);
    add(0, 8'hFF, 0, 1, 0, 0);
    for (int k = 1; k <= 8; k++) begin
      add(0, 8'hFF, 0, 1, 3'(k - 1), 0);
      add(0, 8'hFF, 1, 1, 3'(k % 8), 0);
    end
    // forced revoke after 4 cycles
    add(1, 8'h00, 0, 0, 0, 0);
    for (int k = 0; k < 4; k++) add(0, 8'h21, 0, 1, 0, 0);
    add(0, 8'h21, 0, 1, 5, 1);
    add(0, 8'h21, 0, 1, 5, 0);
    add(0, 8'h00, 0, 0, 5, 0);
    // release coinciding with the limit is a normal exit
    add(1, 8'h00, 0, 0, 0, 0);
    for (int k = 0; k < 4; k++) add(0, 8'h21, 0, 1, 0, 0);
    add(0, 8'h21, 1, 1, 5, 0);
    add(0, 8'h21, 0, 1, 5, 0);
    // owner dropping its request at the limit is a normal exit
    add(1, 8'h00, 0, 0, 0, 0);
    for (int k = 0; k < 4; k++) add(0, 8'h21, 0, 1, 0, 0);
    add(0, 8'h20, 0, 1, 5, 0);
    // sole requester re-wins after timeout with tenure restarted
    add(1, 8'h00, 0, 0, 0, 0);
    for (int k = 0; k < 4; k++) add(0, 8'h01, 0, 1, 0, 0);
    add(0, 8'h01, 0, 1, 0, 1);
    for (int k = 0; k < 3; k++) add(0, 8'h01, 0, 1, 0, 0);
    add(0, 8'h01, 0, 1, 0, 1);
    // non-owner changes ignored; release ignored in IDLE
    add(1, 8'h00, 0, 0, 0, 0);
    add(0, 8'h01, 0, 1, 0, 0);
    add(0, 8'h03, 0, 1, 0, 0);
    add(0, 8'h0F, 0, 1, 0, 0);
    add(1, 8'h00, 0, 0, 0, 0);
    add(0, 8'h02, 1, 1, 1, 0);
    add(0, 8'h02, 1, 1, 1, 0);

    for (int i = 0; i < vecs.size(); i++) apply(i, vecs[i]);

    // HOLD_MAX == 0: owner keeps the grant indefinitely, no timeout
    @(negedge clk);
    reset = 1'b1; req = 8'h00; rel = 1'b0;
    @(negedge clk);
    reset = 1'b0; req = 8'h21;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk);
      #1;
      check("nolimit_code", k, 32'(gnt_code0), 32'd0);
      check("nolimit_timeout", k, 32'(timeout0), 32'd0);
    end
    @(negedge clk);
    rel = 1'b1;
    @(posedge clk);
    #1;
    check("nolimit_release", 0, 32'(gnt_code0), 32'd5);
    check("nolimit_valid", 0, 32'(gnt_valid0), 32'd1);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
